// File: rtl/mux4_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin output-channel arbiter.
// FSM encodings, index/one-hot widths and a one-hot helper.
package mux4_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_32b.sv
// Four-input word multiplexer driven by a 2-bit select.
module mux4_32b #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] out_data
);

    always_comb begin
        out_data = in0;
        case (control)
            2'd0:    out_data = in0;
            2'd1:    out_data = in1;
            2'd2:    out_data = in2;
            default: out_data = in3;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first unmasked request at or after i_ptr (mod 4).
module rr_pick4
    import mux4_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_idx
);

    logic [NUM_REQ-1:0] w_elig;
    logic [IDX_W-1:0]   w_cand;

    assign w_elig = i_req & ~i_mask;
    assign o_any  = |w_elig;

    // Walk offsets from farthest to nearest so the nearest eligible one wins.
    always_comb begin
        o_idx  = i_ptr;
        w_cand = i_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = i_ptr + IDX_W'(k);
            if (w_elig[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter sharing one output channel between 4 requesters, with bounded bursts
// and a valid/ready handshake downstream.
module mux4_arbiter
    import mux4_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [WIDTH-1:0]   in3,
    input  logic               out_ready,
    output logic [3:0]         grant,
    output logic [3:0]         ack,
    output logic [1:0]         control,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output arb_state_t         o_dbg_state
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    // Handshake: a word moves when out_valid && out_ready on a rising edge;
    // out_valid is the granted requester's req, ack flags that same cycle.
    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_control;
    logic [NUM_REQ-1:0] r_grant;
    logic [BW-1:0]      r_burst_cnt;

    logic               w_active;
    logic               w_xfer;
    logic               w_others;
    logic               w_room;
    logic               w_keep;
    logic               w_release;
    logic               w_any;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_pick_ptr;
    logic [NUM_REQ-1:0] w_pick_mask;

    assign w_active  = (r_state == ARB_GRANT);
    assign out_valid = w_active & req[r_control];
    assign w_xfer    = out_valid & out_ready;
    assign ack       = r_grant & {NUM_REQ{w_xfer}};
    assign w_others  = |(req & ~r_grant);
    assign w_room    = (int'(r_burst_cnt) + 1) < MAX_BURST;
    assign w_keep    = w_xfer & (w_room | ~w_others);
    assign w_release = w_active & (~req[r_control] | (w_xfer & ~w_keep));

    assign grant       = r_grant;
    assign control     = r_control;
    assign o_dbg_state = r_state;

    // While granted, re-arbitration starts after the current owner and excludes it.
    assign w_pick_ptr  = w_active ? (r_control + IDX_W'(1)) : r_ptr;
    assign w_pick_mask = w_active ? r_grant : '0;

    rr_pick4 u_pick (
        .i_req  (req),
        .i_mask (w_pick_mask),
        .i_ptr  (w_pick_ptr),
        .o_any  (w_any),
        .o_idx  (w_idx)
    );

    mux4_32b #(.WIDTH(WIDTH)) u_mux (
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .control  (r_control),
        .out_data (out_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_control   <= '0;
            r_burst_cnt <= '0;
        end else if (r_state == ARB_IDLE) begin
            if (w_any) begin
                r_state     <= ARB_GRANT;
                r_grant     <= onehot4(w_idx);
                r_control   <= w_idx;
                r_burst_cnt <= '0;
            end
        end else if (w_keep) begin
            if (int'(r_burst_cnt) < MAX_BURST - 1) begin
                r_burst_cnt <= r_burst_cnt + BW'(1);
            end
        end else if (w_release) begin
            r_ptr       <= r_control + IDX_W'(1);
            r_burst_cnt <= '0;
            if (w_any) begin
                r_grant   <= onehot4(w_idx);
                r_control <= w_idx;
            end else begin
                r_state <= ARB_IDLE;
                r_grant <= '0;
            end
        end
    end

endmodule
